decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 43 ++++
 rtl/decode_stage_regfile.sv | 44 ++++
 rtl/decode_stage.sv | 171 +++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared instruction definitions: field positions, widths, opcodes and field helpers.
// Imported by decode_stage and regfile.
package decode_stage_pkg;

  localparam int LEN_OPECODE = 6;
  localparam int LEN_REG     = 32;
  localparam int LEN_INSN    = 32;
  localparam int NUM_REG     = 32;
  localparam int LEN_IDX     = 5;
  localparam int LEN_IMM     = 15;

  localparam int POS_OPECODE_LO = 26;
  localparam int POS_IMMF       = 25;
  localparam int POS_RD_LO      = 20;
  localparam int POS_RS_LO      = 15;
  localparam int POS_IMM_LO     = 0;

  localparam logic [LEN_OPECODE-1:0] OPECODE_NOP = 6'h00;
  localparam logic [LEN_OPECODE-1:0] OPECODE_ADD = 6'h01;

  typedef struct packed {
    logic [LEN_OPECODE-1:0] opecode;
    logic                   immf;
    logic [LEN_IDX-1:0]     rd;
    logic [LEN_IDX-1:0]     rs;
    logic [LEN_IMM-1:0]     imm15;
  } insn_fields_t;

  function automatic insn_fields_t split_insn(input logic [LEN_INSN-1:0] insn);
    insn_fields_t f;
    f.opecode = insn[POS_OPECODE_LO +: LEN_OPECODE];
    f.immf    = insn[POS_IMMF];
    f.rd      = insn[POS_RD_LO +: LEN_IDX];
    f.rs      = insn[POS_RS_LO +: LEN_IDX];
    f.imm15   = insn[POS_IMM_LO +: LEN_IMM];
    return f;
  endfunction

  function automatic logic [LEN_REG-1:0] sext_imm(input logic [LEN_IMM-1:0] imm);
    return {{(LEN_REG-LEN_IMM){imm[LEN_IMM-1]}}, imm};
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// General register file: NUM_REG x LEN_REG, two asynchronous read ports,
// one synchronous write port, every register writable and cleared on reset.
module regfile
  import decode_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [LEN_IDX-1:0] widx,
  input  logic [LEN_REG-1:0] wdata,
  input  logic [LEN_IDX-1:0] ra_idx,
  input  logic [LEN_IDX-1:0] rb_idx,
  output logic [LEN_REG-1:0] ra_data,
  output logic [LEN_REG-1:0] rb_data
);

  logic [LEN_REG-1:0] regs_q [NUM_REG];
  logic [LEN_REG-1:0] regs_d [NUM_REG];

  // next register contents: single write port
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[widx] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // register array storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= {LEN_REG{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_idx];
  assign rb_data = regs_q[rb_idx];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits the instruction, reads operands and holds one decoded
// entry for execute. Optional macro DECODE_BYPASS_EN forwards writeback data.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   insn_valid,
  input  logic [LEN_INSN-1:0]    insn,
  output logic                   insn_ready,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [LEN_OPECODE-1:0] opecode,
  output logic                   immf,
  output logic [LEN_IDX-1:0]     rd_idx,
  output logic [LEN_REG-1:0]     data_rd,
  output logic [LEN_REG-1:0]     data_rs,
  output logic [LEN_REG-1:0]     imm_ex,
  output logic                   carry,
  input  logic                   wb_en,
  input  logic [LEN_IDX-1:0]     wb_idx,
  input  logic [LEN_REG-1:0]     wb_data,
  input  logic                   wb_carry_en,
  input  logic                   wb_carry
);

  insn_fields_t           fields_s;
  logic                   accept_s;
  logic [LEN_REG-1:0]     rd_rdata_s, rs_rdata_s;
  logic [LEN_REG-1:0]     rd_read_s, rs_read_s;

  logic                   ex_valid_q, ex_valid_d;
  logic [LEN_OPECODE-1:0] opecode_q, opecode_d;
  logic                   immf_q, immf_d;
  logic [LEN_IDX-1:0]     rd_idx_q, rd_idx_d;
  logic [LEN_REG-1:0]     data_rd_q, data_rd_d;
  logic [LEN_REG-1:0]     data_rs_q, data_rs_d;
  logic [LEN_REG-1:0]     imm_ex_q, imm_ex_d;
  logic                   carry_q, carry_d;
`ifdef DECODE_BYPASS_EN
  logic [LEN_IDX-1:0]     rs_idx_q, rs_idx_d;
`endif

  assign fields_s   = split_insn(insn);
  assign insn_ready = !ex_valid_q || ex_ready;
  assign accept_s   = insn_valid && insn_ready;

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .widx    (wb_idx),
    .wdata   (wb_data),
    .ra_idx  (fields_s.rd),
    .rb_idx  (fields_s.rs),
    .ra_data (rd_rdata_s),
    .rb_data (rs_rdata_s)
  );

  // operand read, optionally forwarding a same-cycle writeback
  always_comb begin
    rd_read_s = rd_rdata_s;
    rs_read_s = rs_rdata_s;
`ifdef DECODE_BYPASS_EN
    if (wb_en && (wb_idx == fields_s.rd)) begin
      rd_read_s = wb_data;
    end else begin
      rd_read_s = rd_rdata_s;
    end
    if (wb_en && (wb_idx == fields_s.rs)) begin
      rs_read_s = wb_data;
    end else begin
      rs_read_s = rs_rdata_s;
    end
`endif
  end

  // output slot next state: load on accept, drain on consume, else hold
  always_comb begin
    ex_valid_d = ex_valid_q;
    opecode_d  = opecode_q;
    immf_d     = immf_q;
    rd_idx_d   = rd_idx_q;
    data_rd_d  = data_rd_q;
    data_rs_d  = data_rs_q;
    imm_ex_d   = imm_ex_q;
`ifdef DECODE_BYPASS_EN
    rs_idx_d   = rs_idx_q;
`endif
    if (accept_s) begin
      ex_valid_d = 1'b1;
      opecode_d  = fields_s.opecode;
      immf_d     = fields_s.immf;
      rd_idx_d   = fields_s.rd;
      data_rd_d  = rd_read_s;
      data_rs_d  = rs_read_s;
      imm_ex_d   = sext_imm(fields_s.imm15);
`ifdef DECODE_BYPASS_EN
      rs_idx_d   = fields_s.rs;
`endif
    end else begin
      if (ex_ready) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = ex_valid_q;
      end
`ifdef DECODE_BYPASS_EN
      // keep a held entry's operands coherent with later writebacks
      if (wb_en && (wb_idx == rd_idx_q)) begin
        data_rd_d = wb_data;
      end else begin
        data_rd_d = data_rd_q;
      end
      if (wb_en && (wb_idx == rs_idx_q)) begin
        data_rs_d = wb_data;
      end else begin
        data_rs_d = data_rs_q;
      end
`endif
    end
  end

  // carry flag next state
  always_comb begin
    carry_d = carry_q;
    if (wb_carry_en) begin
      carry_d = wb_carry;
    end else begin
      carry_d = carry_q;
    end
  end

  // stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      opecode_q  <= {LEN_OPECODE{1'b0}};
      immf_q     <= 1'b0;
      rd_idx_q   <= {LEN_IDX{1'b0}};
      data_rd_q  <= {LEN_REG{1'b0}};
      data_rs_q  <= {LEN_REG{1'b0}};
      imm_ex_q   <= {LEN_REG{1'b0}};
      carry_q    <= 1'b0;
`ifdef DECODE_BYPASS_EN
      rs_idx_q   <= {LEN_IDX{1'b0}};
`endif
    end else begin
      ex_valid_q <= ex_valid_d;
      opecode_q  <= opecode_d;
      immf_q     <= immf_d;
      rd_idx_q   <= rd_idx_d;
      data_rd_q  <= data_rd_d;
      data_rs_q  <= data_rs_d;
      imm_ex_q   <= imm_ex_d;
      carry_q    <= carry_d;
`ifdef DECODE_BYPASS_EN
      rs_idx_q   <= rs_idx_d;
`endif
    end
  end

  assign ex_valid = ex_valid_q;
  assign opecode  = opecode_q;
  assign immf     = immf_q;
  assign rd_idx   = rd_idx_q;
  assign data_rd  = data_rd_q;
  assign data_rs  = data_rs_q;
  assign imm_ex   = imm_ex_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver feeds directed and random stimulus
// into a register-array model; a monitor checks every presented output entry.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        insn_valid = 1'b0;
  logic [31:0] insn = 32'h0;
  logic        insn_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [5:0]  opecode;
  logic        immf;
  logic [4:0]  rd_idx;
  logic [31:0] data_rd, data_rs, imm_ex;
  logic        carry;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_idx = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        wb_carry_en = 1'b0;
  logic        wb_carry = 1'b0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .insn_valid(insn_valid), .insn(insn),
    .insn_ready(insn_ready), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .opecode(opecode), .immf(immf), .rd_idx(rd_idx), .data_rd(data_rd),
    .data_rs(data_rs), .imm_ex(imm_ex), .carry(carry), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .wb_carry_en(wb_carry_en),
    .wb_carry(wb_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        immf;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [31:0] drd;
    logic [31:0] drs;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] regs_m [32];
  logic        carry_m;
  bit          bypass_m;
  logic        pend_v;
  logic [4:0]  pend_idx;
  logic [31:0] pend_data;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic im,
                                     input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [14:0] imm);
    return {op, im, rd, rs, imm};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
    carry_m = 1'b0;
    pend_v  = 1'b0;
    sb.delete();
  endtask

  // one clock of stimulus; model updated with the rules of the stage
  task automatic drive(input logic iv, input logic [31:0] ins, input logic exr,
                       input logic wbe, input logic [4:0] wbi, input logic [31:0] wbd,
                       input logic wce, input logic wc);
    bit   occupied, acc;
    exp_t e;
    @(negedge clk);
    chk("carry", {31'h0, carry}, {31'h0, carry_m});
    occupied = (sb.size() > 0);
    insn_valid = iv; insn = ins; ex_ready = exr;
    wb_en = wbe; wb_idx = wbi; wb_data = wbd;
    wb_carry_en = wce; wb_carry = wc;
    acc = iv && (!occupied || exr);
    #1;
    chk("insn_ready", {31'h0, insn_ready}, {31'h0, (!occupied || exr)});
    chk("ex_valid", {31'h0, ex_valid}, {31'h0, occupied});
    if (acc) begin
      e.op   = ins[31:26];
      e.immf = ins[25];
      e.rd   = ins[24:20];
      e.rs   = ins[19:15];
      e.imm  = $signed(ins[14:0]);
      e.drd  = (bypass_m && wbe && wbi == e.rd) ? wbd : regs_m[e.rd];
      e.drs  = (bypass_m && wbe && wbi == e.rs) ? wbd : regs_m[e.rs];
      sb.push_back(e);
    end else if (bypass_m && occupied && !exr && wbe) begin
      pend_v = 1'b1; pend_idx = wbi; pend_data = wbd;
    end
    if (wbe) regs_m[wbi] = wbd;
    if (wce) carry_m = wc;
  endtask

  task automatic idle(input logic exr);
    drive(1'b0, 32'h0, exr, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wb(input logic [4:0] idx, input logic [31:0] d);
    drive(1'b0, 32'h0, 1'b1, 1'b1, idx, d, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    insn_valid = 1'b0; ex_ready = 1'b0; wb_en = 1'b0; wb_carry_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
    chk("rst_carry", {31'h0, carry}, 32'h0);
    chk("rst_data_rd", data_rd, 32'h0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: compare the presented entry, pop it when execute takes it
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ex_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'h0, 32'h1);
        end else begin
          chk("op_immf_rd", {20'h0, opecode, immf, rd_idx},
              {20'h0, sb[0].op, sb[0].immf, sb[0].rd});
          chk("imm_ex", imm_ex, sb[0].imm);
          chk("data_rd", data_rd, sb[0].drd);
          chk("data_rs", data_rs, sb[0].drs);
          if (ex_ready) begin
            void'(sb.pop_front());
          end else if (pend_v) begin
            if (pend_idx == sb[0].rd) sb[0].drd = pend_data;
            if (pend_idx == sb[0].rs) sb[0].drs = pend_data;
          end
        end
      end
      pend_v = 1'b0;
    end
  end

  initial begin
`ifdef DECODE_BYPASS_EN
    bypass_m = 1'b1;
`else
    bypass_m = 1'b0;
`endif
    clear_model();
    #2;
    chk("init_ex_valid", {31'h0, ex_valid}, 32'h0);
    chk("init_carry", {31'h0, carry}, 32'h0);
    chk("init_outputs", data_rd | data_rs | imm_ex | {26'h0, opecode} | {31'h0, immf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // operand read after writeback preload
    wb(5'd1, 32'h1);
    wb(5'd3, 32'h3);
    drive(1'b1, mk(OPECODE_ADD, 1'b0, 5'd1, 5'd3, 15'h0), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b1);

    // immediate sign extension
    drive(1'b1, mk(OPECODE_ADD, 1'b1, 5'd4, 5'd5, 15'h7fff), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, mk(OPECODE_ADD, 1'b1, 5'd6, 5'd7, 15'h3fff), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b1);

    // stall three cycles then back-to-back accepts
    drive(1'b1, mk(6'h2a, 1'b0, 5'd1, 5'd3, 15'h1234), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, mk(6'h15, 1'b1, 5'd9, 5'd8, 15'h0abc), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b1, mk(6'(i + 3), 1'b0, 5'(i), 5'(i + 1), 15'(i * 7)), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b1);

    // writeback colliding with an accept reading the same register
    wb(5'd2, 32'h12345678);
    drive(1'b1, mk(OPECODE_ADD, 1'b0, 5'd2, 5'd2, 15'h0), 1'b1, 1'b1, 5'd2, 32'hffffffff, 1'b0, 1'b0);
    idle(1'b1);

    // writeback while an entry is held
    drive(1'b1, mk(OPECODE_ADD, 1'b0, 5'd3, 5'd1, 15'h0), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 32'hdeadbeef, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // carry flag then reset in the middle of a hold
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, mk(OPECODE_ADD, 1'b0, 5'd1, 5'd3, 15'h5), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    reset_pulse();
    drive(1'b1, mk(OPECODE_ADD, 1'b0, 5'd1, 5'd3, 15'h6), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
